// File: rtl/mul_pkg.sv
// Shared definitions for the iterative carry-save multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } mul_state_t;

    localparam int DEF_MUL_WIDTH = 32;
    localparam int DEF_ACC_WIDTH = 2 * DEF_MUL_WIDTH;

    // Accumulator width needed to hold a full product of two w-bit operands.
    function automatic int acc_width_of(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_csa.sv
// One 3:2 carry-save stage: reduces three addends to a sum and a carry word.
module mul_csa #(
    parameter int BIT_WIDTH = mul_pkg::DEF_ACC_WIDTH
) (
    input  logic [BIT_WIDTH-1:0] x_i,
    input  logic [BIT_WIDTH-1:0] y_i,
    input  logic [BIT_WIDTH-1:0] z_i,
    output logic [BIT_WIDTH-1:0] sum_o,
    output logic [BIT_WIDTH-1:0] carry_o
);

    logic [BIT_WIDTH-1:0] maj;

    assign maj     = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
    assign sum_o   = x_i ^ y_i ^ z_i;
    // Carry weight is one position up; the top carry falls off (mod 2^BIT_WIDTH).
    assign carry_o = {maj[BIT_WIDTH-2:0], 1'b0};

endmodule

// File: rtl/mul_csa_iter.sv
// Iterative sign-magnitude multiplier: one partial product per cycle folded
// into carry-save accumulators, then a single carry-propagate add at the end.
module mul_csa_iter
    import mul_pkg::*;
#(
    parameter int MUL_WIDTH = DEF_MUL_WIDTH
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 start,
    input  logic                 flush,
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic                 high,
    output logic                 busy,
    output logic                 done,
    output logic [MUL_WIDTH-1:0] result
);

    localparam int ACC_WIDTH = acc_width_of(MUL_WIDTH);
    localparam int IDX_W     = $clog2(MUL_WIDTH);
    localparam int CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_WIDTH - 1);

    mul_state_t           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [MUL_WIDTH-1:0] a_mag_q, b_mag_q;
    logic                 neg_q, high_q;
    logic [ACC_WIDTH-1:0] sum_q, carry_q;
    logic [MUL_WIDTH-1:0] result_q;

    logic                 a_neg_d, b_neg_d;
    logic [MUL_WIDTH-1:0] a_mag_d, b_mag_d;
    logic [ACC_WIDTH-1:0] pp_d, csa_sum_d, csa_carry_d;
    logic [ACC_WIDTH-1:0] prod_d, prod_signed_d;
    logic [MUL_WIDTH-1:0] result_d;

    // Operand magnitudes and product sign, captured when a multiply is accepted.
    always_comb begin
        a_neg_d = a_signed & a[MUL_WIDTH-1];
        b_neg_d = b_signed & b[MUL_WIDTH-1];
        a_mag_d = a_neg_d ? (~a + MUL_WIDTH'(1)) : a;
        b_mag_d = b_neg_d ? (~b + MUL_WIDTH'(1)) : b;
    end

    // Partial product for the current multiplier bit.
    always_comb begin
        pp_d = '0;
        if (b_mag_q[cnt_q[IDX_W-1:0]]) begin
            pp_d = {{(ACC_WIDTH-MUL_WIDTH){1'b0}}, a_mag_q} << cnt_q[IDX_W-1:0];
        end
    end

    mul_csa #(
        .BIT_WIDTH(ACC_WIDTH)
    ) u_csa (
        .x_i    (sum_q),
        .y_i    (carry_q),
        .z_i    (pp_d),
        .sum_o  (csa_sum_d),
        .carry_o(csa_carry_d)
    );

    // Final carry-propagate add, sign restore and half selection.
    always_comb begin
        prod_d        = sum_q + carry_q;
        prod_signed_d = neg_q ? (~prod_d + ACC_WIDTH'(1)) : prod_d;
        result_d      = high_q ? prod_signed_d[ACC_WIDTH-1:MUL_WIDTH]
                               : prod_signed_d[MUL_WIDTH-1:0];
    end

    // Control FSM with its datapath registers; flush returns to IDLE from anywhere.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            high_q   <= 1'b0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        a_mag_q <= a_mag_d;
                        b_mag_q <= b_mag_d;
                        neg_q   <= a_neg_d ^ b_neg_d;
                        high_q  <= high;
                        sum_q   <= '0;
                        carry_q <= '0;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        sum_q   <= csa_sum_d;
                        carry_q <= csa_carry_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= result_d;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: doc/mul_csa_iter.md
MUL_CSA_ITER -- requirements
Module: mul_csa_iter

Interface
REQ-001 SHALL have parameter MUL_WIDTH, default 32: operand width in bits.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port flush  input  1  abort any operation in progress.
REQ-006 SHALL have port a  input  MUL_WIDTH  multiplicand.
REQ-007 SHALL have port b  input  MUL_WIDTH  multiplier.
REQ-008 SHALL have port a_signed  input  1  treat a as two's complement.
REQ-009 SHALL have port b_signed  input  1  treat b as two's complement.
REQ-010 SHALL have port high  input  1  1 = return upper MUL_WIDTH bits of product, 0 = lower.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-013 SHALL have port result  output  MUL_WIDTH  selected product half.

Function
REQ-014 SHALL implement states IDLE, ACCUM, RESOLVE, DONE.
REQ-015 SHALL, on an edge in IDLE with start=1 and flush=0, latch a, b, a_signed, b_signed and high; clear both accumulators and the iteration counter; enter ACCUM.
REQ-016 SHALL convert each signed-flagged negative operand to its magnitude at capture; -2^(MUL_WIDTH-1) maps to unsigned 2^(MUL_WIDTH-1).
REQ-017 SHALL record product sign as (a_signed & a_msb) XOR (b_signed & b_msb).
REQ-018 SHALL, in each ACCUM cycle i (0..MUL_WIDTH-1), form pp = b_mag[i] ? (a_mag zero-extended to 2*MUL_WIDTH) << i : 0.
REQ-019 SHALL reduce {sum_acc, carry_acc, pp} through one 2*MUL_WIDTH carry-save stage and register the sum and carry into the accumulators each ACCUM cycle.
REQ-020 SHALL leave ACCUM for RESOLVE after exactly MUL_WIDTH cycles; early termination is not performed.
REQ-021 SHALL, in RESOLVE, compute prod = sum_acc + carry_acc (2*MUL_WIDTH bits, carry-out discarded), two's-negate when the sign is set, and register prod[2W-1:W] if high else prod[W-1:0] into result.
REQ-022 SHALL go RESOLVE -> DONE -> IDLE; done=1 only in DONE; latency is MUL_WIDTH+2 cycles from the accepting edge to the first cycle done is high (34 for W=32).
REQ-023 SHALL hold result stable from DONE until the next RESOLVE update.
REQ-024 SHALL ignore start while busy=1; a start held high in DONE is sampled in the following IDLE cycle.
REQ-025 SHALL, on flush=1 in any state, enter IDLE at the next edge, suppress done and leave result unchanged.
REQ-026 SHALL give flush priority when start and flush are both high in IDLE: no operation starts.
REQ-027 SHALL accept back-to-back operations with exactly one IDLE cycle between done and the next acceptance.

Reset
REQ-028 SHALL, on nRST low, immediately enter IDLE with busy=0, done=0, result=0, accumulators=0 and counter=0, regardless of state.
REQ-029 SHALL not raise done for an operation interrupted by reset.

Structure
REQ-030 SHALL take state enum mul_state_t, MUL_WIDTH default and ACC_WIDTH (=2*MUL_WIDTH) from shared package mul_pkg.
REQ-031 SHALL instantiate exactly one mul_csa with BIT_WIDTH=ACC_WIDTH as the carry-save stage; the carry-propagate add and negation are inline.
REQ-032 SHALL size the iteration counter at $clog2(MUL_WIDTH)+1 bits.

Verification
REQ-033 SHALL cover unsigned 3 x 5, high=0 -> result 0x0000000F, done in cycle 34 after accept.
REQ-034 SHALL cover unsigned 0xFFFFFFFF x 0xFFFFFFFF, high=1 -> 0xFFFFFFFE; high=0 -> 0x00000001.
REQ-035 SHALL cover signed 0x80000000 x 0x80000000, high=1 -> 0x40000000; signed 0xFFFFFFFF x 0xFFFFFFFF, high=1 -> 0x00000000.
REQ-036 SHALL cover a signed 0xFFFFFFFF x b unsigned 0xFFFFFFFF, high=1 -> 0xFFFFFFFF, high=0 -> 0x00000001.
REQ-037 SHALL cover flush at ACCUM cycle 10 -> IDLE next edge, no done, result unchanged; new start with 7 x 6 -> 0x0000002A.
REQ-038 SHALL cover nRST asserted at ACCUM cycle 20 -> busy=0, result=0 immediately; start while busy ignored -> only one done per accepted start.
